// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, EX forwarding, memory-wait hold and multi-cycle branch flush FSM.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs1_D,
  input  logic [4:0]           Rs2_D,
  input  logic [4:0]           Rs1_E,
  input  logic [4:0]           Rs2_E,
  input  logic [4:0]           Rd_E,
  input  logic                 MemRead_E,
  input  logic [4:0]           Rd_M,
  input  logic                 RegWrite_M,
  input  logic [4:0]           Rd_W,
  input  logic                 RegWrite_W,
  input  logic                 PCtaken_E,
  input  logic                 MemBusy_M,
  output logic                 Stall_F,
  output logic                 Stall_D,
  output logic                 Stall_E,
  output logic                 Flush_D,
  output logic                 flush,
  output logic                 LWflush,
  output logic [1:0]           ForwardA_E,
  output logic [1:0]           ForwardB_E,
  output logic [CNT_WIDTH-1:0] StallCnt,
  output logic [CNT_WIDTH-1:0] FlushCnt
);

  localparam int PW = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY + 1) : 1;
  localparam logic [PW-1:0] PEN_FULL   = PW'(BRANCH_PENALTY);
  localparam logic [PW-1:0] PEN_RELOAD = PW'(BRANCH_PENALTY - 1);
  localparam logic [PW-1:0] ONE        = PW'(1);

  typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] cnt, cnt_nxt;
  logic          pend, pend_nxt;
  logic          lu, run_eval;
  logic          stall_fd, stall_e, flush_i, lw_i;
  logic [1:0]    fa, fb;

  assign lu = MemRead_E && (Rd_E != '0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  always_comb begin
    fa = 2'b00;
    if (RegWrite_M && (Rd_M != '0) && (Rd_M == Rs1_E))      fa = 2'b10;
    else if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs1_E)) fa = 2'b01;
    fb = 2'b00;
    if (RegWrite_M && (Rd_M != '0) && (Rd_M == Rs2_E))      fb = 2'b10;
    else if (RegWrite_W && (Rd_W != '0) && (Rd_W == Rs2_E)) fb = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    stall_fd  = 1'b0;
    stall_e   = 1'b0;
    flush_i   = 1'b0;
    lw_i      = 1'b0;
    run_eval  = 1'b0;

    case (state)
      RUN: run_eval = 1'b1;
      FLUSH: begin
        if (MemBusy_M) begin
          stall_fd  = 1'b1;
          stall_e   = 1'b1;
          pend_nxt  = 1'b1;
          cnt_nxt   = PCtaken_E ? PEN_FULL : cnt;
          state_nxt = MEMWAIT;
        end else begin
          flush_i = 1'b1;
          if (PCtaken_E) begin
            cnt_nxt = PEN_RELOAD;
          end else if (cnt <= ONE) begin
            cnt_nxt   = '0;
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
      end
      MEMWAIT: begin
        if (MemBusy_M) begin
          stall_fd = 1'b1;
          stall_e  = 1'b1;
          if (PCtaken_E && !pend) begin
            pend_nxt = 1'b1;
            cnt_nxt  = PEN_FULL;
          end
        end else if (pend) begin
          // Busy just dropped: the saved flush sequence starts in this same cycle.
          flush_i  = 1'b1;
          pend_nxt = 1'b0;
          if (cnt > ONE) begin
            cnt_nxt   = cnt - ONE;
            state_nxt = FLUSH;
          end else begin
            cnt_nxt   = '0;
            state_nxt = RUN;
          end
        end else begin
          run_eval = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (run_eval) begin
      state_nxt = RUN;
      if (MemBusy_M) begin
        stall_fd  = 1'b1;
        stall_e   = 1'b1;
        state_nxt = MEMWAIT;
        if (PCtaken_E) begin
          pend_nxt = 1'b1;
          cnt_nxt  = PEN_FULL;
        end
      end else if (PCtaken_E) begin
        flush_i = 1'b1;
        if (BRANCH_PENALTY > 1) begin
          cnt_nxt   = PEN_RELOAD;
          state_nxt = FLUSH;
        end
      end else if (lu) begin
        stall_fd = 1'b1;
        lw_i     = 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is asserted so the pipe sees a clean state immediately.
  assign Stall_F    = rst_n & stall_fd;
  assign Stall_D    = rst_n & stall_fd;
  assign Stall_E    = rst_n & stall_e;
  assign Flush_D    = rst_n & flush_i;
  assign flush      = rst_n & flush_i;
  assign LWflush    = rst_n & lw_i;
  assign ForwardA_E = rst_n ? fa : 2'b00;
  assign ForwardB_E = rst_n ? fb : 2'b00;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_fd && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush_i && (flush_cnt != '1))  flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (BRANCH_PENALTY=2) with a queue scoreboard.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic        MemRead_E, RegWrite_M, RegWrite_W, PCtaken_E, MemBusy_M;
  logic        Stall_F, Stall_D, Stall_E, Flush_D, flush, LWflush;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] StallCnt, FlushCnt;

  typedef logic [9:0] exp_t;
  exp_t        sb[$];
  string       tq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.BRANCH_PENALTY(2), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .MemRead_E(MemRead_E), .Rd_M(Rd_M), .RegWrite_M(RegWrite_M),
    .Rd_W(Rd_W), .RegWrite_W(RegWrite_W), .PCtaken_E(PCtaken_E), .MemBusy_M(MemBusy_M),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Flush_D(Flush_D),
    .flush(flush), .LWflush(LWflush), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  // {Stall_F, Stall_D, Stall_E, Flush_D, flush, LWflush, ForwardA_E, ForwardB_E}
  function automatic exp_t mk(bit sf, bit sd, bit se, bit fd, bit fl, bit lw,
                              logic [1:0] fa, logic [1:0] fb);
    return {sf, sd, se, fd, fl, lw, fa, fb};
  endfunction

  task automatic idle();
    Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0; Rd_E = '0; Rd_M = '0; Rd_W = '0;
    MemRead_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    PCtaken_E = 1'b0; MemBusy_M = 1'b0;
  endtask

  task automatic step(input exp_t e, input string tag);
    exp_t  obs, want;
    string t;
    sb.push_back(e);
    tq.push_back(tag);
    if (rst_n) begin
      m_stall += 32'(e[9]);
      m_flush += 32'(e[5]);
    end
    #2;
    obs  = {Stall_F, Stall_D, Stall_E, Flush_D, flush, LWflush, ForwardA_E, ForwardB_E};
    want = sb.pop_front();
    t    = tq.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, obs, want);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [63:0] want;
`ifdef HAZARD_PERF_CNT_EN
    want = {m_stall, m_flush};
`else
    want = '0;
`endif
    checks++;
    assert ({StallCnt, FlushCnt} === want) else begin
      errors++;
      $error("FAIL %s observed=%0d/%0d expected=%0d/%0d", tag, StallCnt, FlushCnt,
             want[63:32], want[31:0]);
    end
  endtask

  initial begin
    exp_t Z, FL, ST, LU;
    Z  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    FL = mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00);
    ST = mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00);
    LU = mk(1, 1, 0, 0, 0, 1, 2'b00, 2'b00);

    idle(); rst_n = 1'b0;
    #12 step(Z, "reset_outputs");
    chk_cnt("reset_counters");
    @(negedge clk); rst_n = 1'b1; idle(); step(Z, "idle");

    @(negedge clk); idle(); MemRead_E = 1; Rd_E = 5; Rs1_D = 5; step(LU, "lu_rs1");
    @(negedge clk); idle(); step(Z, "lu_released");
    @(negedge clk); idle(); MemRead_E = 1; Rd_E = 9; Rs2_D = 9; Rs1_D = 3; step(LU, "lu_rs2");
    @(negedge clk); idle(); MemRead_E = 1; Rd_E = 0; Rs1_D = 0; step(Z, "lu_x0_exempt");
    @(negedge clk); idle(); MemRead_E = 0; Rd_E = 5; Rs1_D = 5; step(Z, "no_load_no_stall");

    @(negedge clk); idle(); Rd_M = 7; Rd_W = 7; RegWrite_M = 1; RegWrite_W = 1; Rs1_E = 7;
    step(mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00), "fwdA_mem_priority");
    RegWrite_M = 0; @(negedge clk); step(mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00), "fwdA_wb");
    @(negedge clk); idle(); Rd_M = 7; RegWrite_M = 1; Rs2_E = 7; Rd_W = 3; RegWrite_W = 1; Rs1_E = 3;
    step(mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10), "fwd_A_wb_B_mem");
    @(negedge clk); idle(); Rd_M = 0; RegWrite_M = 1; Rd_W = 0; RegWrite_W = 1;
    step(Z, "fwd_x0_exempt");

    @(negedge clk); idle(); PCtaken_E = 1; step(FL, "branch_c1");
    @(negedge clk); idle(); step(FL, "branch_c2");
    @(negedge clk); idle(); step(Z, "branch_done");

    @(negedge clk); idle(); PCtaken_E = 1; MemRead_E = 1; Rd_E = 4; Rs1_D = 4;
    step(FL, "branch_beats_lu");
    @(negedge clk); idle(); step(FL, "branch_lu_c2");
    @(negedge clk); idle(); step(Z, "branch_lu_done");

    @(negedge clk); idle(); MemBusy_M = 1; PCtaken_E = 1; step(ST, "membusy_c1");
    @(negedge clk); idle(); MemBusy_M = 1; Rd_M = 7; RegWrite_M = 1; Rs1_E = 7;
    step(mk(1, 1, 1, 0, 0, 0, 2'b10, 2'b00), "membusy_c2_fwd");
    @(negedge clk); idle(); MemBusy_M = 1; step(ST, "membusy_c3");
    @(negedge clk); idle(); step(FL, "pending_flush_c1");
    @(negedge clk); idle(); step(FL, "pending_flush_c2");
    @(negedge clk); idle(); step(Z, "pending_done");

    @(negedge clk); idle(); PCtaken_E = 1; step(FL, "reload_c1");
    @(negedge clk); idle(); PCtaken_E = 1; step(FL, "reload_c2");
    @(negedge clk); idle(); step(FL, "reload_c3");
    @(negedge clk); idle(); step(Z, "reload_done");

    @(negedge clk); idle(); PCtaken_E = 1; step(FL, "flushbusy_c1");
    @(negedge clk); idle(); MemBusy_M = 1; step(ST, "flushbusy_wait");
    @(negedge clk); idle(); step(FL, "flushbusy_resume");
    @(negedge clk); idle(); step(Z, "flushbusy_done");

    @(negedge clk); idle(); MemBusy_M = 1; step(ST, "wait_nopend");
    @(negedge clk); idle(); MemRead_E = 1; Rd_E = 6; Rs1_D = 6; step(LU, "wait_exit_lu");
    @(negedge clk); idle(); step(Z, "wait_exit_idle");
    chk_cnt("counters_mid");

    @(negedge clk); idle(); PCtaken_E = 1; step(FL, "pre_reset_flush");
    idle(); rst_n = 1'b0; m_stall = 0; m_flush = 0;
    step(Z, "async_reset_outputs");
    chk_cnt("async_reset_counters");
    @(negedge clk); rst_n = 1'b1; idle(); step(Z, "run_after_reset");
    @(negedge clk); idle(); PCtaken_E = 1; step(FL, "post_reset_branch");
    @(negedge clk); idle(); step(FL, "post_reset_branch_c2");
    @(negedge clk); idle(); step(Z, "post_reset_done");

    @(posedge clk); #1 chk_cnt("final_counters");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
